// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution feeder.
package conv_pkg;

  localparam int KERNEL_WORDS = 9;
  localparam int DEF_WIDTH    = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    FIN
  } feeder_state_t;

endpackage

// File: rtl/conv_feeder_skid.sv
// Two-entry output FIFO between the memory return path and the PE.
// Each entry carries a word plus its weight/data tag in the top bit.
module conv_feeder_skid #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [1:0]    count
);

  logic [DW-1:0] entry_reg [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: ;
      endcase
    end
  end

  assign valid = (count_reg != 2'd0);
  assign data  = entry_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/conv_feeder.sv
// Convolution feeder: reads a 3x3 kernel then an image frame from memory and streams them to a PE.
// Defining CONV_FEEDER_PAD_EN adds a one-pixel zero border around the frame.
module conv_feeder
  import conv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  weight_out,
  output logic              weight_valid,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  feeder_state_t     state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        kidx_reg;
  logic              rvalid_reg;
  logic              rtag_reg;

  logic              fifo_valid;
  logic [WIDTH:0]    fifo_data;
  logic [1:0]        fifo_count;

  logic              pop;
  logic              push;
  logic [WIDTH:0]    push_data;
  logic [2:0]        free_slots;
  logic              room;
  logic              item_weight;
  logic              want_item;
  logic              pad_item;
  logic              last_pix;
  logic              rd_issue;
  logic              pad_push;
  logic              item_adv;

  // A slot being drained this cycle counts as free, which keeps one read per cycle flowing.
  assign pop        = fifo_valid & out_ready;
  assign free_slots = 3'd2 - {1'b0, fifo_count} + {2'b0, pop};
  assign room       = free_slots > {2'b0, rvalid_reg};

  assign item_weight = (state_reg == IDLE) || (state_reg == LOAD_W);
  assign want_item   = (state_reg == IDLE) ? start
                     : ((state_reg == LOAD_W) || (state_reg == STREAM));
  assign rd_issue    = want_item && !pad_item && room;
  // Border zeros wait for the in-flight read so they cannot overtake it.
  assign pad_push    = pad_item && room && !rvalid_reg;
  assign item_adv    = rd_issue || pad_push;

  assign push      = rvalid_reg || pad_push;
  assign push_data = rvalid_reg ? {rtag_reg, mem_rdata} : '0;

  // The first kernel read goes out in the start cycle to reach valid two cycles later.
  assign mem_rd_en = rd_issue;
  assign mem_addr  = (state_reg == IDLE) ? (start ? base_addr : '0) : addr_reg;

  assign weight_valid = fifo_valid &  fifo_data[WIDTH];
  assign data_valid   = fifo_valid & ~fifo_data[WIDTH];
  assign weight_out   = weight_valid ? fifo_data[WIDTH-1:0] : '0;
  assign data_out     = data_valid   ? fifo_data[WIDTH-1:0] : '0;

`ifdef CONV_FEEDER_PAD_EN
  localparam int ROW_W = $clog2(IMG_H + 2);
  localparam int COL_W = $clog2(IMG_W + 2);

  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;

  assign pad_item = (state_reg == STREAM) &&
                    ((row_reg == '0) || (row_reg == ROW_W'(IMG_H + 1)) ||
                     (col_reg == '0) || (col_reg == COL_W'(IMG_W + 1)));
  assign last_pix = (row_reg == ROW_W'(IMG_H + 1)) && (col_reg == COL_W'(IMG_W + 1));

  always_ff @(posedge clk) begin
    if (!rst_n || state_reg == IDLE) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (state_reg == STREAM && item_adv) begin
      if (col_reg == COL_W'(IMG_W + 1)) begin
        col_reg <= '0;
        row_reg <= row_reg + ROW_W'(1);
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end
`else
  localparam int PIX_W = $clog2(IMG_W * IMG_H + 1);

  logic [PIX_W-1:0] pix_reg;

  assign pad_item = 1'b0;
  assign last_pix = (pix_reg == PIX_W'(IMG_W * IMG_H - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || state_reg == IDLE) pix_reg <= '0;
    else if (state_reg == STREAM && item_adv) pix_reg <= pix_reg + PIX_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      kidx_reg   <= 4'd0;
      rvalid_reg <= 1'b0;
      rtag_reg   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rvalid_reg <= rd_issue;
      rtag_reg   <= item_weight;
      done       <= 1'b0;
      if (rd_issue) addr_reg <= addr_reg + ADDR_W'(1);
      unique case (state_reg)
        IDLE: begin
          if (rd_issue) begin
            state_reg <= LOAD_W;
            addr_reg  <= base_addr + ADDR_W'(1);
            kidx_reg  <= 4'd1;
            busy      <= 1'b1;
          end
        end
        LOAD_W: begin
          if (item_adv) begin
            kidx_reg <= kidx_reg + 4'd1;
            if (kidx_reg == 4'(KERNEL_WORDS - 1)) state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (item_adv && last_pix) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (fifo_count == 2'd0 && !rvalid_reg) begin
            state_reg <= FIN;
            done      <= 1'b1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  conv_feeder_skid #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .valid    (fifo_valid),
    .data     (fifo_data),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_conv_feeder.sv
// Scoreboard bench for conv_feeder: random memory contents and ready patterns against a raster-order model.
module tb_conv_feeder;

  localparam int WIDTH  = 9;
  localparam int IMG_W  = 10;
  localparam int IMG_H  = 10;
  localparam int ADDR_W = 16;
  localparam int KW     = 9;
  localparam int MEMN   = 1 << ADDR_W;
`ifdef CONV_FEEDER_PAD_EN
  localparam int NDATA  = (IMG_W + 2) * (IMG_H + 2);
`else
  localparam int NDATA  = IMG_W * IMG_H;
`endif
  localparam int NTOTAL = KW + NDATA;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic [WIDTH-1:0]  weight_out;
  logic              weight_valid;
  logic [WIDTH-1:0]  data_out;
  logic              data_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;

  conv_feeder #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .weight_out  (weight_out),
    .weight_valid(weight_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [0:MEMN-1];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [WIDTH:0] exp_q[$];
  int  accepts = 0;
  int  done_cnt = 0;
  int  first_valid_cyc = -1;
  int  first_acc_cyc = 0;
  int  last_acc_cyc = 0;
  int  ready_mode = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // out_ready pattern: 0 always high, 1 high one cycle in three, 2 random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every transfer, checks stability while stalled.
  initial begin
    bit             stalled = 1'b0;
    logic [WIDTH:0] held = '0;
    logic [WIDTH:0] cur;
    logic [WIDTH:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (weight_valid || data_valid) begin
          check_eq("valid_exclusive", {31'd0, weight_valid & data_valid}, 32'd0);
          cur = {weight_valid, weight_valid ? weight_out : data_out};
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (stalled) check_eq("stable_while_stalled", {22'd0, cur}, {22'd0, held});
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check_eq("unexpected_word", {22'd0, cur}, 32'hFFFF_FFFF);
            end else begin
              exp_w = exp_q.pop_front();
              check_eq("word", {22'd0, cur}, {22'd0, exp_w});
            end
            if (accepts == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            accepts++;
            stalled = 1'b0;
            $display("accept #%0d tag=%0d word=%0h cycle=%0d", accepts, cur[WIDTH], cur[WIDTH-1:0], cyc);
          end else begin
            stalled = 1'b1;
            held    = cur;
          end
        end else if (stalled) begin
          check_eq("valid_dropped", 32'd0, 32'd1);
          stalled = 1'b0;
        end
        if (done) begin
          done_cnt++;
          check_eq("done_after_last", exp_q.size(), 32'd0);
          check_eq("done_delay", {31'd0, (cyc - last_acc_cyc >= 1) && (cyc - last_acc_cyc <= 2)}, 32'd1);
        end
      end
    end
  end

  task automatic fill_mem(input logic [ADDR_W-1:0] base, input int mode);
    for (int k = 0; k < NTOTAL; k++) begin
      if (mode == 0) mem[(int'(base) + k) % MEMN] = WIDTH'(k + 1);
      else mem[(int'(base) + k) % MEMN] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
    end
  endtask

  // Reference: kernel words, then the frame in raster order (optionally ringed by zeros).
  task automatic build_expected(input logic [ADDR_W-1:0] base);
    int a;
    a = int'(base);
    exp_q.delete();
    for (int k = 0; k < KW; k++) begin
      exp_q.push_back({1'b1, mem[a % MEMN]});
      a++;
    end
`ifdef CONV_FEEDER_PAD_EN
    for (int r = 0; r < IMG_H + 2; r++) begin
      for (int c = 0; c < IMG_W + 2; c++) begin
        if (r == 0 || r == IMG_H + 1 || c == 0 || c == IMG_W + 1) begin
          exp_q.push_back({1'b0, {WIDTH{1'b0}}});
        end else begin
          exp_q.push_back({1'b0, mem[a % MEMN]});
          a++;
        end
      end
    end
`else
    for (int i = 0; i < NDATA; i++) begin
      exp_q.push_back({1'b0, mem[a % MEMN]});
      a++;
    end
`endif
  endtask

  task automatic begin_transfer(input logic [ADDR_W-1:0] base, input int fill, input int rmode,
                                output int start_cyc);
    fill_mem(base, fill);
    build_expected(base);
    accepts         = 0;
    done_cnt        = 0;
    first_valid_cyc = -1;
    ready_mode      = rmode;
    repeat (2) @(posedge clk);
    #1;
    base_addr = base;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic run(input logic [ADDR_W-1:0] base, input int fill, input int rmode, input bit poke);
    int start_cyc;
    int n;
    begin_transfer(base, fill, rmode, start_cyc);
    if (poke) begin
      n = 0;
      while (accepts < 20 && n < 2000) begin @(posedge clk); n++; end
      #1;
      base_addr = ~base;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 5000) begin @(posedge clk); n++; end
    if (done_cnt == 0) check_eq("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_count", done_cnt, 32'd1);
    check_eq("accept_count", accepts, NTOTAL);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    check_eq("busy_after_done", {31'd0, busy}, 32'd0);
    if (rmode == 0) begin
      check_eq("first_valid_latency", first_valid_cyc - start_cyc, 32'd2);
`ifndef CONV_FEEDER_PAD_EN
      check_eq("full_throughput", last_acc_cyc - first_acc_cyc, NTOTAL - 1);
`endif
    end
    $display("transfer base=%0h ready_mode=%0d accepts=%0d done=%0d", base, rmode, accepts, done_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    check_eq({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    check_eq({tag, "_weight_valid"}, {31'd0, weight_valid}, 32'd0);
    check_eq({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
    check_eq({tag, "_weight_out"}, {23'd0, weight_out}, 32'd0);
    check_eq({tag, "_data_out"}, {23'd0, data_out}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int start_cyc;
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run(16'h0100, 0, 0, 1'b0);
    run(16'h0100, 0, 1, 1'b0);
    run(ADDR_W'($urandom), 1, 2, 1'b1);
    run(16'hFFF8, 1, 2, 1'b0);

    // Reset in the middle of a transfer, then a clean restart.
    begin_transfer(16'h0300, 1, 0, start_cyc);
    n = 0;
    while (accepts < 40 && n < 2000) begin @(negedge clk); n++; end
    if (accepts < 40) check_eq("mid_reset_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_eq("no_done_on_reset", done_cnt, 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    run(16'h0200, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 9, data/weight word width.
REQ-002 SHALL have parameter IMG_W, default 10, image columns.
REQ-003 SHALL have parameter IMG_H, default 10, image rows.
REQ-004 SHALL have parameter ADDR_W, default 12, memory address width.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port start, input, 1, begin one kernel+frame transfer.
REQ-008 SHALL have port base_addr, input, ADDR_W, kernel/frame base address, sampled with start.
REQ-009 SHALL have port mem_rd_en, output, 1, memory read strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W, read address, valid with mem_rd_en.
REQ-011 SHALL have port mem_rdata, input, WIDTH, read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port weight_out, output, WIDTH, weight word to PE.
REQ-013 SHALL have port weight_valid, output, 1, weight_out valid.
REQ-014 SHALL have port data_out, output, WIDTH, pixel word to PE.
REQ-015 SHALL have port data_valid, output, 1, data_out valid.
REQ-016 SHALL have port out_ready, input, 1, PE accepts current word.
REQ-017 SHALL have port busy, output, 1, high from accepted start until done.
REQ-018 SHALL have port done, output, 1, one-cycle pulse after last pixel accepted.

Function
REQ-019 FSM states IDLE, LOAD_W, STREAM, DRAIN, FIN; start in IDLE -> LOAD_W, latching base_addr; start outside IDLE ignored.
REQ-020 LOAD_W reads base_addr+0..+8 in order, emits 9 words on weight_out; -> STREAM when 9th read issued.
REQ-021 STREAM reads base_addr+9 onward, IMG_W*IMG_H words raster order; -> DRAIN when last read issued.
REQ-022 DRAIN waits until all buffered words accepted, -> FIN; FIN asserts done one cycle, -> IDLE.
REQ-023 Transfer occurs when (weight_valid|data_valid)&&out_ready; word and valid held stable until transfer.
REQ-024 weight_valid and data_valid never high in the same cycle; all 9 weights accepted before first data_valid.
REQ-025 Words emitted verbatim, including zero weights; no reordering, drop or duplication.
REQ-026 Read issued only if buffer free slots > reads in flight; at most one read per cycle.
REQ-027 With out_ready held high, one word accepted per cycle after 2-cycle initial latency (start -> first valid).
REQ-028 Address arithmetic modulo 2^ADDR_W; wrap past all-ones silently continues from 0.
REQ-029 out_ready low any number of cycles stalls reads; no overflow, no loss.

Reset
REQ-030 rst_n low at any edge: FSM -> IDLE, buffer emptied, in-flight read discarded.
REQ-031 Reset values: mem_rd_en 0, mem_addr 0, weight_valid 0, data_valid 0, weight_out 0, data_out 0, busy 0, done 0.
REQ-032 Reset mid-transfer produces no done pulse; next start begins a fresh transfer.

Configuration
REQ-033 Macro CONV_FEEDER_PAD_EN defined: STREAM emits (IMG_W+2)*(IMG_H+2) words, border positions zero, no memory read for border words.
REQ-034 CONV_FEEDER_PAD_EN undefined: STREAM emits IMG_W*IMG_H words, all from memory; no padding logic present.

Structure
REQ-035 Shared package conv_pkg holds KERNEL_WORDS=9, default WIDTH, feeder FSM state typedef.
REQ-036 Output buffering in sub-module conv_feeder_skid: 2-entry FIFO, WIDTH+1 bits (word + weight/data tag).

Verification
REQ-037 rst_n released, start with base_addr=0x100, out_ready=1, mem[k]=k+1 -> weights 1..9, then data 10..109, done 1 cycle after 100th accept.
REQ-038 out_ready toggled 1-of-3 cycles -> same sequence, no gap/duplicate, each word stable while stalled.
REQ-039 start pulsed again while busy -> ignored; exactly one done, 109 accepts.
REQ-040 rst_n low after 40 accepts -> all outputs reset values next cycle, no done; new start restarts from weight 0.
REQ-041 base_addr=0xFFF8 (ADDR_W=16) -> reads wrap 0xFFFF->0x0000, sequence intact.
REQ-042 CONV_FEEDER_PAD_EN defined -> 144 data words, first 13 and all border words zero, interior equals mem data.
